fpu_mantissa_multiplier: RTL and testbench

Sequential radix-2 shift-add multiplier stage of the single-precision FPU multiplier, sitting directly upstream of the normalization stage. Accepts two IEEE-754 single operands and unpacks them. Produces the sign, the biased exponent sum and the upper 24 bits of the 48-bit mantissa product, plus a sticky bit. These outputs feed the normalizer's 24-bit fraction and 8-bit exponent inputs. Valid/ready handshakes on both sides; one multiplication in flight.

---
 rtl/fpu_pkg.sv | 26 ++
 rtl/fpu_mantissa_multiplier_if.sv | 31 +++
 rtl/fpu_exp_adder.sv | 21 ++
 rtl/fpu_mantissa_multiplier.sv | 115 +++++++++++
 tb/tb_fpu_mantissa_multiplier.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: widths, bias, operand layout and multiplier states.
package fpu_pkg;

  localparam int unsigned MANT_W = 24;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned BIAS   = 127;

  // Signed width of ea+eb-BIAS: covers -125..383.
  localparam int unsigned SUM_W  = EXP_W + 2;

  // Largest biased exponent that is still finite.
  localparam logic signed [SUM_W-1:0] EXP_MAX = 10'sd254;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-2:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    DONE
  } mult_state_t;

endpackage

// File: rtl/fpu_mantissa_multiplier_if.sv
// Operand/result handshake bundle between the multiplier stage and its neighbours.
interface fpu_mantissa_multiplier_if;
  import fpu_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [31:0]       op_a;
  logic [31:0]       op_b;
  logic              out_valid;
  logic              out_ready;
  logic              sign;
  logic [MANT_W-1:0] fraction;
  logic [EXP_W-1:0]  exponent;
  logic              sticky;
  logic              zero;
  logic              exp_overflow;
  logic              exp_underflow;

  modport master (
    output in_valid, op_a, op_b, out_ready,
    input  in_ready, out_valid, sign, fraction, exponent, sticky, zero,
           exp_overflow, exp_underflow
  );

  modport slave (
    input  in_valid, op_a, op_b, out_ready,
    output in_ready, out_valid, sign, fraction, exponent, sticky, zero,
           exp_overflow, exp_underflow
  );

endinterface

// File: rtl/fpu_exp_adder.sv
// Combinational biased-exponent adder with range flags; shared with the normalizer.
module fpu_exp_adder
  import fpu_pkg::*;
(
  input  logic [EXP_W-1:0]        ea,
  input  logic [EXP_W-1:0]        eb,
  output logic signed [SUM_W-1:0] sum,
  output logic                    exp_overflow,
  output logic                    exp_underflow,
  output logic                    zero
);

  // Sum, zero detect (denormals flush to zero) and flags, suppressed for zero results.
  always_comb begin
    sum           = signed'({2'b00, ea} + {2'b00, eb} - SUM_W'(BIAS));
    zero          = (ea == '0) || (eb == '0);
    exp_overflow  = !zero && ((sum > EXP_MAX) || (ea == '1) || (eb == '1));
    exp_underflow = !zero && (sum[SUM_W-1] || (sum == '0));
  end

endmodule

// File: rtl/fpu_mantissa_multiplier.sv
// Radix-2 shift-add mantissa multiplier: one multiplier bit per cycle, LSB first.
// Produces sign, biased exponent, product[47:24] and a sticky bit for the normalizer.
module fpu_mantissa_multiplier
  import fpu_pkg::*;
(
  input logic                      clk,
  input logic                      rst,
  fpu_mantissa_multiplier_if.slave bus
);

  localparam logic [4:0] LAST = 5'(MANT_W - 1);

  fp32_t                   a;
  fp32_t                   b;
  mult_state_t             state_q, state_d;
  logic                    rdy_q;
  logic                    accept;
  logic signed [SUM_W-1:0] sum;
  logic                    add_ovf, add_unf, add_zero;
  logic                    unused_sum_hi;

  logic [MANT_W-1:0]       mcand_q;
  logic [MANT_W-1:0]       mpl_q;
  logic [2*MANT_W-1:0]     acc_q, acc_d;
  logic [MANT_W:0]         psum;
  logic [4:0]              cnt_q;
  logic                    sign_q;
  logic [EXP_W-1:0]        exp_q;
  logic                    ovf_q, unf_q, zero_q;

  assign a      = bus.op_a;
  assign b      = bus.op_b;
  assign accept = bus.in_valid && bus.in_ready;

  fpu_exp_adder u_exp_adder (
    .ea            (a.exp),
    .eb            (b.exp),
    .sum           (sum),
    .exp_overflow  (add_ovf),
    .exp_underflow (add_unf),
    .zero          (add_zero)
  );

  // Only the low byte is forwarded; the flags already qualify the upper bits.
  assign unused_sum_hi = ^sum[SUM_W-1:EXP_W];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; zero operands skip the iteration entirely.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = add_zero ? DONE : MULT;
      MULT:    if (cnt_q == LAST) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One shift-add step: add the multiplicand into the upper half, shift right.
  always_comb begin
    psum = {1'b0, acc_q[2*MANT_W-1:MANT_W]};
    if (mpl_q[0]) psum = psum + {1'b0, mcand_q};
    acc_d = {psum, acc_q[MANT_W-1:1]};
  end

  // Datapath: operand capture on accept, iteration in MULT, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q   <= 1'b0;
      mcand_q <= '0;
      mpl_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      // Holds in_ready low for the first cycle after reset release.
      rdy_q <= 1'b1;
      if (accept) begin
        mcand_q <= {1'b1, a.frac};
        mpl_q   <= {1'b1, b.frac};
        acc_q   <= '0;
        cnt_q   <= '0;
        sign_q  <= a.sign ^ b.sign;
        exp_q   <= add_zero ? '0 : sum[EXP_W-1:0];
        ovf_q   <= add_ovf;
        unf_q   <= add_unf;
        zero_q  <= add_zero;
      end else if (state_q == MULT) begin
        acc_q <= acc_d;
        mpl_q <= mpl_q >> 1;
        if (cnt_q != LAST) cnt_q <= cnt_q + 5'd1;
      end
    end
  end

  assign bus.in_ready      = (state_q == IDLE) && rdy_q;
  assign bus.out_valid     = (state_q == DONE);
  assign bus.sign          = sign_q;
  assign bus.fraction      = acc_q[2*MANT_W-1:MANT_W];
  assign bus.exponent      = exp_q;
  assign bus.sticky        = |acc_q[MANT_W-1:0];
  assign bus.zero          = zero_q;
  assign bus.exp_overflow  = ovf_q;
  assign bus.exp_underflow = unf_q;

endmodule

// File: tb/tb_fpu_mantissa_multiplier.sv
// Scoreboard bench for the mantissa multiplier stage: directed vectors, backpressure,
// busy-input rejection and mid-operation reset.
module tb_fpu_mantissa_multiplier;
  import fpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpu_mantissa_multiplier_if bus ();

  fpu_mantissa_multiplier dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic [36:0] res;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  logic prev_valid = 1'b0;

  // Result packing: {sign, fraction, exponent, sticky, zero, ovf, unf}.
  function automatic logic [36:0] pk(input logic s, input logic [23:0] f, input logic [7:0] e,
                                     input logic st, input logic z, input logic o,
                                     input logic u);
    return {s, f, e, st, z, o, u};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  function automatic logic [36:0] dut_res();
    return pk(bus.sign, bus.fraction, bus.exponent, bus.sticky, bus.zero,
              bus.exp_overflow, bus.exp_underflow);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every presented result against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.in_valid && bus.in_ready) acc_cyc = cyc + 1;
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", {27'd0, dut_res()}, 64'd0);
        end else begin
          e = sb[0];
          chk(e.name, {27'd0, dut_res()}, {27'd0, e.res});
          chk({e.name, "_in_ready"}, {63'd0, bus.in_ready}, 64'd0);
          if (!prev_valid) chk({e.name, "_latency"}, 64'(cyc - acc_cyc + 1), 64'(e.lat));
          if (bus.out_ready) void'(sb.pop_front());
        end
      end
      prev_valid = bus.out_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic send(input string nm, input logic [31:0] a, input logic [31:0] b,
                      input logic [36:0] r, input int lat);
    exp_t e;
    wait_ready();
    chk({nm, "_accept"}, {63'd0, bus.in_ready}, 64'd1);
    if (bus.in_ready) begin
      e.name = nm;
      e.res  = r;
      e.lat  = lat;
      sb.push_back(e);
      bus.op_a     = a;
      bus.op_b     = b;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk({nm, "_drain"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int n;
    bus.in_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_outputs", {27'd0, dut_res()}, 64'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("release_in_ready_low", {63'd0, bus.in_ready}, 64'd0);
    @(posedge clk); #1;
    chk("release_in_ready_high", {63'd0, bus.in_ready}, 64'd1);

    // Main function
    send("one_x_one", 32'h3F800000, 32'h3F800000, pk(0, 24'h400000, 8'd127, 0, 0, 0, 0), 25);
    send("onehalf_sq", 32'h3FC00000, 32'h3FC00000, pk(0, 24'h900000, 8'd127, 0, 0, 0, 0), 25);
    send("neg2_x_3", 32'hC0000000, 32'h40400000, pk(1, 24'h600000, 8'd129, 0, 0, 0, 0), 25);
    // Operands offered while busy must be ignored.
    bus.op_a     = 32'h3F800001;
    bus.op_b     = 32'h40400000;
    bus.in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    send("sticky", 32'h3F800001, 32'h3F800001, pk(0, 24'h400001, 8'd127, 1, 0, 0, 0), 25);
    send("ovf", 32'h7F000000, 32'h7F000000, pk(0, 24'h400000, 8'h7D, 0, 0, 1, 0), 25);
    send("unf", 32'h00800000, 32'h00800000, pk(0, 24'h400000, 8'h83, 0, 0, 0, 1), 25);
    send("zero", 32'h00000000, 32'hBF800000, pk(1, 24'h0, 8'h0, 0, 1, 0, 0), 1);
    send("sum_254", 32'h7F000000, 32'h3F800000, pk(0, 24'h400000, 8'd254, 0, 0, 0, 0), 25);
    send("sum_0", 32'h00800000, 32'h3F000000, pk(0, 24'h400000, 8'd0, 0, 0, 0, 1), 25);
    send("sum_1", 32'h00800000, 32'h3F800000, pk(0, 24'h400000, 8'd1, 0, 0, 0, 0), 25);
    send("exp_255", 32'h7F800000, 32'h00800000, pk(0, 24'h400000, 8'h81, 0, 0, 1, 0), 25);
    send("zero_255", 32'h7F800000, 32'h80000000, pk(1, 24'h0, 8'h0, 0, 1, 0, 0), 1);
    wait_drain("vectors");

    // Backpressure: result must hold for 10 stalled cycles
    bus.out_ready = 1'b0;
    send("stall", 32'h3FC00000, 32'h3FC00000, pk(0, 24'h900000, 8'd127, 0, 0, 0, 0), 25);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("stall_valid", {63'd0, bus.out_valid}, 64'd1);
    repeat (10) @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_drain("stall");

    // Reset at MULT cycle 12 abandons the operation
    wait_ready();
    bus.op_a     = 32'h3F800000;
    bus.op_b     = 32'h3F800000;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("midrst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("midrst_outputs", {27'd0, dut_res()}, 64'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("midrst_release_low", {63'd0, bus.in_ready}, 64'd0);
    @(posedge clk); #1;
    chk("midrst_release_high", {63'd0, bus.in_ready}, 64'd1);
    send("after_rst", 32'h3F800000, 32'h3F800000, pk(0, 24'h400000, 8'd127, 0, 0, 0, 0), 25);
    wait_drain("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
